// File: rtl/piso_framer.sv
// Parallel-in serial-out framer: start bit, WIDTH data bits, optional even parity.
// Every output is a register that updates on the same edge as the FSM.
module piso_framer #(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             frame_active,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, START, DATA, PARITY} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             serial_out_q, serial_out_d;
  logic             frame_active_q, frame_active_d;
  logic             frame_done_q, frame_done_d;
  logic             load_ready_q, load_ready_d;

  logic             next_bit;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    if (MSB_FIRST != 0) begin
      next_bit = shift_q[WIDTH-1];
      shifted  = {shift_q[WIDTH-2:0], 1'b0};
    end else begin
      next_bit = shift_q[0];
      shifted  = {1'b0, shift_q[WIDTH-1:1]};
    end
  end

  // The state names what serial_out is carrying during the current cycle.
  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    cnt_d          = cnt_q;
    par_d          = par_q;
    serial_out_d   = serial_out_q;
    frame_active_d = frame_active_q;
    frame_done_d   = 1'b0;
    load_ready_d   = load_ready_q;
    unique case (state_q)
      IDLE: begin
        serial_out_d   = 1'b0;
        frame_active_d = 1'b0;
        load_ready_d   = 1'b1;
        if (load_valid && load_ready_q) begin
          state_d        = START;
          shift_d        = data_in;
          par_d          = ^data_in;
          cnt_d          = '0;
          serial_out_d   = 1'b1;
          frame_active_d = 1'b1;
          load_ready_d   = 1'b0;
        end
      end
      START: begin
        state_d      = DATA;
        serial_out_d = next_bit;
        shift_d      = shifted;
        cnt_d        = CW'(1);
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          if (PARITY_EN != 0) begin
            state_d      = PARITY;
            serial_out_d = par_q;
          end else begin
            state_d        = IDLE;
            serial_out_d   = 1'b0;
            frame_active_d = 1'b0;
            frame_done_d   = 1'b1;
            load_ready_d   = 1'b1;
          end
        end else begin
          serial_out_d = next_bit;
          shift_d      = shifted;
          cnt_d        = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        state_d        = IDLE;
        serial_out_d   = 1'b0;
        frame_active_d = 1'b0;
        frame_done_d   = 1'b1;
        load_ready_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      cnt_q          <= '0;
      par_q          <= 1'b0;
      serial_out_q   <= 1'b0;
      frame_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
      load_ready_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      cnt_q          <= cnt_d;
      par_q          <= par_d;
      serial_out_q   <= serial_out_d;
      frame_active_q <= frame_active_d;
      frame_done_q   <= frame_done_d;
      load_ready_q   <= load_ready_d;
    end
  end

  assign load_ready   = load_ready_q;
  assign serial_out   = serial_out_q;
  assign frame_active = frame_active_q;
  assign frame_done   = frame_done_q;

endmodule
